// File: rtl/led_bar_sequencer.sv
// LED bar source sequencer: picks CPU data-out, CPU data-in or port FF for the
// SBC LED bar. Sources are chosen by the switches, rotated automatically, or
// held on port FF for a fixed time after each CPU write to that port.
module led_bar_sequencer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int HOLD_CYCLES  = 25_000_000
) (
    input  logic       pll0_100MHz,
    input  logic       n_reset,
    input  logic [7:0] cpuDO,
    input  logic [7:0] cpuDI,
    input  logic [7:0] portFFDO,
    input  logic [1:0] sw,
    input  logic       auto_en,
    input  logic       portFF_wr,
    output logic [7:0] LEDoutData,
    output logic [1:0] src_sel,
    output logic       hold_active
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e        state_q;
    logic [1:0]    src_q;
    logic [1:0]    resume_q;
    logic [DW-1:0] dwell_q;
    logic [HW-1:0] hold_q;
    logic          hold_act_q;
    logic [7:0]    led_q;
    logic [7:0]    bus_sel;

    // Switch 5 wins over switch 4: any 1x pattern picks port FF.
    function automatic logic [1:0] decode_sw(input logic [1:0] s);
        return s[1] ? 2'd2 : {1'b0, s[0]};
    endfunction

    // Round-robin order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Mode FSM; a port FF write outranks every other event on the same edge.
    always_ff @(posedge pll0_100MHz or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= MANUAL;
            src_q      <= 2'd0;
            resume_q   <= 2'd0;
            dwell_q    <= '0;
            hold_q     <= '0;
            hold_act_q <= 1'b0;
        end else if (portFF_wr) begin
            // A retrigger keeps the source saved on first entry.
            if (state_q != HOLD) resume_q <= src_q;
            state_q    <= HOLD;
            src_q      <= 2'd2;
            hold_q     <= HOLD_LAST;
            hold_act_q <= 1'b1;
        end else begin
            case (state_q)
                MANUAL: begin
                    if (auto_en) begin
                        state_q <= AUTO;
                        src_q   <= 2'd0;
                        dwell_q <= '0;
                    end else begin
                        src_q <= decode_sw(sw);
                    end
                end
                AUTO: begin
                    if (!auto_en) begin
                        state_q <= MANUAL;
                        src_q   <= decode_sw(sw);
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        src_q   <= next_src(src_q);
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        hold_act_q <= 1'b0;
                        if (auto_en) begin
                            state_q <= AUTO;
                            src_q   <= resume_q;
                            dwell_q <= '0;
                        end else begin
                            state_q <= MANUAL;
                            src_q   <= decode_sw(sw);
                        end
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= MANUAL;
            endcase
        end
    end

    // Source mux feeding the LED register.
    always_comb begin
        bus_sel = portFFDO;
        case (src_q)
            2'd0:    bus_sel = cpuDO;
            2'd1:    bus_sel = cpuDI;
            default: bus_sel = portFFDO;
        endcase
    end

    // LEDs are active-low; all off in reset.
    always_ff @(posedge pll0_100MHz or negedge n_reset) begin
        if (!n_reset) led_q <= 8'hFF;
        else          led_q <= ~bus_sel;
    end

    assign LEDoutData  = led_q;
    assign src_sel     = src_q;
    assign hold_active = hold_act_q;

endmodule
